// File: rtl/instr_enc_pkg.sv
// Shared types for the instruction encoder: op enum, MIPS opcode/funct values,
// FSM states and word-packing helpers.
package instr_enc_pkg;

   // 30 ops are encoded; op codes 30 and 31 are illegal.
   typedef enum logic [4:0] {
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT,
      OP_SLL, OP_SRL, OP_JR, OP_MUL,
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI,
      OP_BEQ, OP_BNE,
      OP_LW, OP_LH, OP_LB, OP_SW, OP_SH, OP_SB,
      OP_BLEZ, OP_BGTZ, OP_BLTZ, OP_BGEZ,
      OP_J, OP_JAL
   } opType;

   localparam int NUM_OPS = 30;

   localparam logic [5:0] OPC_SPECIAL  = 6'b000000;
   localparam logic [5:0] OPC_SPECIAL2 = 6'b011100;
   localparam logic [5:0] OPC_REGIMM   = 6'b000001;
   localparam logic [5:0] OPC_J        = 6'b000010;
   localparam logic [5:0] OPC_JAL      = 6'b000011;
   localparam logic [5:0] OPC_BEQ      = 6'b000100;
   localparam logic [5:0] OPC_BNE      = 6'b000101;
   localparam logic [5:0] OPC_BLEZ     = 6'b000110;
   localparam logic [5:0] OPC_BGTZ     = 6'b000111;
   localparam logic [5:0] OPC_ADDI     = 6'b001000;
   localparam logic [5:0] OPC_SLTI     = 6'b001010;
   localparam logic [5:0] OPC_ANDI     = 6'b001100;
   localparam logic [5:0] OPC_ORI      = 6'b001101;
   localparam logic [5:0] OPC_XORI     = 6'b001110;
   localparam logic [5:0] OPC_LB       = 6'b100000;
   localparam logic [5:0] OPC_LH       = 6'b100001;
   localparam logic [5:0] OPC_LW       = 6'b100011;
   localparam logic [5:0] OPC_SB       = 6'b101000;
   localparam logic [5:0] OPC_SH       = 6'b101001;
   localparam logic [5:0] OPC_SW       = 6'b101011;

   localparam logic [5:0] FN_SLL = 6'b000000;
   localparam logic [5:0] FN_SRL = 6'b000010;
   localparam logic [5:0] FN_JR  = 6'b001000;
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_XOR = 6'b100110;
   localparam logic [5:0] FN_NOR = 6'b100111;
   localparam logic [5:0] FN_SLT = 6'b101010;
   localparam logic [5:0] FN_MUL = 6'b000010;

   typedef enum logic [1:0] {IDLE, RUN, FULL, DONE} stateType;

   function automatic logic [31:0] packR(input logic [5:0] opc, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [4:0] sh, input logic [5:0] fn);
      return {opc, rs, rt, rd, sh, fn};
   endfunction

   function automatic logic [31:0] packI(input logic [5:0] opc, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {opc, rs, rt, imm};
   endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational packer: turns an op plus its fields into a 32-bit MIPS word
// and flags ops outside the enum as illegal (word forced to zero).
module instr_field_pack
   import instr_enc_pkg::*;
(
   input  logic [4:0]  op,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [4:0]  shamt,
   input  logic [15:0] imm,
   input  logic [25:0] target,
   output logic [31:0] word,
   output logic        legal
);

   // Fields an op does not use are passed as zero so they never leak into the word.
   always_comb begin
      word  = 32'h0;
      legal = 1'b1;
      case (op)
         OP_ADD:  word = packR(OPC_SPECIAL, rs, rt, rd, 5'd0, FN_ADD);
         OP_SUB:  word = packR(OPC_SPECIAL, rs, rt, rd, 5'd0, FN_SUB);
         OP_AND:  word = packR(OPC_SPECIAL, rs, rt, rd, 5'd0, FN_AND);
         OP_OR:   word = packR(OPC_SPECIAL, rs, rt, rd, 5'd0, FN_OR);
         OP_XOR:  word = packR(OPC_SPECIAL, rs, rt, rd, 5'd0, FN_XOR);
         OP_NOR:  word = packR(OPC_SPECIAL, rs, rt, rd, 5'd0, FN_NOR);
         OP_SLT:  word = packR(OPC_SPECIAL, rs, rt, rd, 5'd0, FN_SLT);
         OP_SLL:  word = packR(OPC_SPECIAL, 5'd0, rt, rd, shamt, FN_SLL);
         OP_SRL:  word = packR(OPC_SPECIAL, 5'd0, rt, rd, shamt, FN_SRL);
         OP_JR:   word = packR(OPC_SPECIAL, rs, 5'd0, 5'd0, 5'd0, FN_JR);
         OP_MUL:  word = packR(OPC_SPECIAL2, rs, rt, rd, 5'd0, FN_MUL);
         OP_ADDI: word = packI(OPC_ADDI, rs, rt, imm);
         OP_ANDI: word = packI(OPC_ANDI, rs, rt, imm);
         OP_ORI:  word = packI(OPC_ORI, rs, rt, imm);
         OP_XORI: word = packI(OPC_XORI, rs, rt, imm);
         OP_SLTI: word = packI(OPC_SLTI, rs, rt, imm);
         OP_BEQ:  word = packI(OPC_BEQ, rs, rt, imm);
         OP_BNE:  word = packI(OPC_BNE, rs, rt, imm);
         OP_LW:   word = packI(OPC_LW, rs, rt, imm);
         OP_LH:   word = packI(OPC_LH, rs, rt, imm);
         OP_LB:   word = packI(OPC_LB, rs, rt, imm);
         OP_SW:   word = packI(OPC_SW, rs, rt, imm);
         OP_SH:   word = packI(OPC_SH, rs, rt, imm);
         OP_SB:   word = packI(OPC_SB, rs, rt, imm);
         OP_BLEZ: word = packI(OPC_BLEZ, rs, 5'd0, imm);
         OP_BGTZ: word = packI(OPC_BGTZ, rs, 5'd0, imm);
         OP_BLTZ: word = packI(OPC_REGIMM, rs, 5'd0, imm);
         OP_BGEZ: word = packI(OPC_REGIMM, rs, 5'd1, imm);
         OP_J:    word = {OPC_J, target};
         OP_JAL:  word = {OPC_JAL, target};
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts op/field requests during a program session and
// writes encoded words to sequential memory addresses. Optional macro
// ENC_ILLEGAL_TRAP_EN turns illegal ops into a sticky error instead of a nop.
module instr_encoder #(
   parameter  int DEPTH  = 256,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              start,
   input  logic              finish,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [4:0]        in_op,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_shamt,
   input  logic [15:0]       in_imm,
   input  logic [25:0]       in_target,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic [ADDR_W:0]   word_count,
   output logic              busy,
   output logic              full,
   output logic              err
);
   import instr_enc_pkg::*;

   stateType          state, nextState;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       packedWord;
   logic              legalOp, accept, doWrite, lastAddr;

   instr_field_pack fieldPack (
      .op     (in_op),
      .rs     (in_rs),
      .rt     (in_rt),
      .rd     (in_rd),
      .shamt  (in_shamt),
      .imm    (in_imm),
      .target (in_target),
      .word   (packedWord),
      .legal  (legalOp)
   );

   assign in_ready = (state == RUN);
   assign busy     = (state == RUN);
   assign full     = (state == FULL);
   // A restart in the same cycle wins over any handshake.
   assign accept   = in_valid && in_ready && !start;
   assign lastAddr = (addr == ADDR_W'(DEPTH - 1));

`ifdef ENC_ILLEGAL_TRAP_EN
   assign doWrite = accept && legalOp;
`else
   assign doWrite = accept;
`endif

   // State register.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) state <= IDLE;
      else       state <= nextState;
   end

   // Session control; finish takes priority over filling the last slot.
   always_comb begin
      nextState = state;
      case (state)
         RUN: begin
            if (start)                     nextState = RUN;
            else if (finish)               nextState = DONE;
            else if (doWrite && lastAddr)  nextState = FULL;
         end
         default: if (start) nextState = RUN;
      endcase
   end

   // Address and word counter; the address parks at the last slot instead of wrapping.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         addr       <= '0;
         word_count <= '0;
      end else if (start) begin
         addr       <= '0;
         word_count <= '0;
      end else if (doWrite) begin
         word_count <= word_count + (ADDR_W+1)'(1);
         if (!lastAddr) addr <= addr + ADDR_W'(1);
      end
   end

   // Registered memory write port, one cycle behind the accept.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= 32'h0;
      end else begin
         imem_we <= doWrite;
         if (doWrite) begin
            imem_addr  <= addr;
            imem_wdata <= legalOp ? packedWord : 32'h0;
         end
      end
   end

`ifdef ENC_ILLEGAL_TRAP_EN
   // Sticky illegal-op flag, cleared only by a new session or reset.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)                     err <= 1'b0;
      else if (start)                err <= 1'b0;
      else if (accept && !legalOp)   err <= 1'b1;
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: spec vectors, a constant encoding
// table, full/finish/reset corner sequences and randomized traffic vs a model.
module tb_instr_encoder;
   import instr_enc_pkg::*;

   localparam int DEPTH = 256;
   localparam int SMALL = 4;
`ifdef ENC_ILLEGAL_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   typedef struct {
      logic [4:0]  op;
      logic [4:0]  rs, rt, rd, shamt;
      logic [15:0] imm;
      logic [25:0] target;
      logic [31:0] expWord;
   } vecT;

   logic        Clk = 1'b0;
   logic        Reset, start, finish, in_valid;
   logic [4:0]  in_op, in_rs, in_rt, in_rd, in_shamt;
   logic [15:0] in_imm;
   logic [25:0] in_target;

   logic        in_ready, imem_we, busy, full, err;
   logic [7:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic [8:0]  word_count;

   logic        sReady, sWe, sBusy, sFull, sErr;
   logic [1:0]  sAddr;
   logic [31:0] sWdata;
   logic [2:0]  sCount;

   instr_encoder #(.DEPTH(DEPTH)) dut (
      .Clk(Clk), .Reset(Reset), .start(start), .finish(finish),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
      .in_imm(in_imm), .in_target(in_target),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .word_count(word_count), .busy(busy), .full(full), .err(err)
   );

   instr_encoder #(.DEPTH(SMALL)) dutSmall (
      .Clk(Clk), .Reset(Reset), .start(start), .finish(finish),
      .in_valid(in_valid), .in_ready(sReady), .in_op(in_op),
      .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
      .in_imm(in_imm), .in_target(in_target),
      .imem_we(sWe), .imem_addr(sAddr), .imem_wdata(sWdata),
      .word_count(sCount), .busy(sBusy), .full(sFull), .err(sErr)
   );

   always #5 Clk = ~Clk;

   int checks = 0;
   int errors = 0;

   // Reference model of the session: 0 idle, 1 open, 2 memory full, 3 closed.
   int          mPhase, mAddr, mCount;
   bit          mErr, expWe;
   int          expAddr;
   logic [31:0] expData;

   vecT tbl[12];

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   function automatic logic [31:0] rw(input int opc, input int rs, input int rt,
                                      input int rd, input int sh, input int fn);
      return (32'(opc) << 26) | (32'(rs) << 21) | (32'(rt) << 16) |
             (32'(rd) << 11) | (32'(sh) << 6) | 32'(fn);
   endfunction

   function automatic logic [31:0] iw(input int opc, input int rs, input int rt, input int imm);
      return (32'(opc) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
   endfunction

   function automatic logic [31:0] refEncode(input vecT v);
      int rs = int'(v.rs), rt = int'(v.rt), rd = int'(v.rd);
      int sh = int'(v.shamt), imm = int'(v.imm);
      case (int'(v.op))
         0:  return rw(0, rs, rt, rd, 0, 32);
         1:  return rw(0, rs, rt, rd, 0, 34);
         2:  return rw(0, rs, rt, rd, 0, 36);
         3:  return rw(0, rs, rt, rd, 0, 37);
         4:  return rw(0, rs, rt, rd, 0, 38);
         5:  return rw(0, rs, rt, rd, 0, 39);
         6:  return rw(0, rs, rt, rd, 0, 42);
         7:  return rw(0, 0, rt, rd, sh, 0);
         8:  return rw(0, 0, rt, rd, sh, 2);
         9:  return rw(0, rs, 0, 0, 0, 8);
         10: return rw(28, rs, rt, rd, 0, 2);
         11: return iw(8, rs, rt, imm);
         12: return iw(12, rs, rt, imm);
         13: return iw(13, rs, rt, imm);
         14: return iw(14, rs, rt, imm);
         15: return iw(10, rs, rt, imm);
         16: return iw(4, rs, rt, imm);
         17: return iw(5, rs, rt, imm);
         18: return iw(35, rs, rt, imm);
         19: return iw(33, rs, rt, imm);
         20: return iw(32, rs, rt, imm);
         21: return iw(43, rs, rt, imm);
         22: return iw(41, rs, rt, imm);
         23: return iw(40, rs, rt, imm);
         24: return iw(6, rs, 0, imm);
         25: return iw(7, rs, 0, imm);
         26: return iw(1, rs, 0, imm);
         27: return iw(1, rs, 1, imm);
         28: return (32'd2 << 26) | 32'(v.target);
         29: return (32'd3 << 26) | 32'(v.target);
         default: return 32'h0;
      endcase
   endfunction

   function automatic vecT mkVec(input int op, input int rs, input int rt, input int rd,
                                 input int sh, input int imm, input int tgt, input logic [31:0] w);
      vecT v;
      v.op = 5'(op); v.rs = 5'(rs); v.rt = 5'(rt); v.rd = 5'(rd); v.shamt = 5'(sh);
      v.imm = 16'(imm); v.target = 26'(tgt); v.expWord = w;
      return v;
   endfunction

   task automatic modelReset();
      mPhase = 0; mAddr = 0; mCount = 0; mErr = 1'b0;
      expWe = 1'b0; expAddr = 0; expData = 32'h0;
   endtask

   task automatic modelEdge(input bit st, input bit fin, input bit val, input vecT v);
      bit legal, wr, reachedEnd;
      expWe = 1'b0;
      reachedEnd = 1'b0;
      if (st) begin
         mPhase = 1; mAddr = 0; mCount = 0; mErr = 1'b0;
      end else if (mPhase == 1) begin
         if (val) begin
            legal = int'(v.op) < NUM_OPS;
            wr = TRAP ? legal : 1'b1;
            if (TRAP && !legal) mErr = 1'b1;
            if (wr) begin
               expWe = 1'b1; expAddr = mAddr;
               expData = legal ? refEncode(v) : 32'h0;
               mCount++;
               if (mAddr == DEPTH - 1) reachedEnd = 1'b1;
               else mAddr++;
            end
         end
         if (fin) mPhase = 3;
         else if (reachedEnd) mPhase = 2;
      end
   endtask

   task automatic applyStimulus(input bit st, input bit fin, input bit val, input vecT v);
      start = st; finish = fin; in_valid = val;
      in_op = v.op; in_rs = v.rs; in_rt = v.rt; in_rd = v.rd; in_shamt = v.shamt;
      in_imm = v.imm; in_target = v.target;
      @(posedge Clk);
      modelEdge(st, fin, val, v);
      @(negedge Clk);
      checkOutput("imem_we", 32'(imem_we), 32'(expWe));
      checkOutput("imem_addr", 32'(imem_addr), 32'(expAddr));
      checkOutput("imem_wdata", imem_wdata, expData);
      checkOutput("word_count", 32'(word_count), 32'(mCount));
      checkOutput("in_ready", 32'(in_ready), 32'(mPhase == 1));
      checkOutput("busy", 32'(busy), 32'(mPhase == 1));
      checkOutput("full", 32'(full), 32'(mPhase == 2));
      checkOutput("err", 32'(err), 32'(mErr));
      start = 1'b0; finish = 1'b0; in_valid = 1'b0;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " imem_we"}, 32'(imem_we), 32'h0);
      checkOutput({tag, " imem_addr"}, 32'(imem_addr), 32'h0);
      checkOutput({tag, " imem_wdata"}, imem_wdata, 32'h0);
      checkOutput({tag, " word_count"}, 32'(word_count), 32'h0);
      checkOutput({tag, " in_ready"}, 32'(in_ready), 32'h0);
      checkOutput({tag, " busy"}, 32'(busy), 32'h0);
      checkOutput({tag, " full"}, 32'(full), 32'h0);
      checkOutput({tag, " err"}, 32'(err), 32'h0);
   endtask

   initial begin
      vecT nul, v;
      int  smallWrites;
      nul = mkVec(0, 0, 0, 0, 0, 0, 0, 32'h0);
      Reset = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
      in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0;
      in_imm = '0; in_target = '0;
      modelReset();

      tbl[0]  = mkVec(OP_ADD,  1, 2, 3, 0, 0, 0, 32'h00221820);
      tbl[1]  = mkVec(OP_SUB,  5, 6, 7, 9, 16'h1234, 0, 32'h00A63822);
      tbl[2]  = mkVec(OP_SLL,  9, 2, 3, 4, 0, 0, 32'h00021900);
      tbl[3]  = mkVec(OP_JR,  31, 7, 7, 7, 0, 0, 32'h03E00008);
      tbl[4]  = mkVec(OP_MUL,  1, 2, 3, 0, 0, 0, 32'h70221802);
      tbl[5]  = mkVec(OP_LW,  29, 8, 3, 0, 4, 0, 32'h8FA80004);
      tbl[6]  = mkVec(OP_BLEZ, 3, 7, 0, 0, 16'h0010, 0, 32'h18600010);
      tbl[7]  = mkVec(OP_BLTZ, 2, 9, 0, 0, 16'hFFFE, 0, 32'h0440FFFE);
      tbl[8]  = mkVec(OP_J,    5, 5, 5, 5, 5, 26'h3FFFFFF, 32'h0BFFFFFF);
      tbl[9]  = mkVec(OP_NOR,  1, 2, 3, 0, 0, 0, 32'h00221827);
      tbl[10] = mkVec(OP_SB,   1, 2, 0, 0, 16'h8000, 0, 32'hA0228000);
      tbl[11] = mkVec(OP_ADDI, 0, 8, 0, 0, 16'hFFFF, 0, 32'h2008FFFF);

      repeat (2) @(negedge Clk);
      checkAllZero("reset");
      Reset = 1'b0;

      $display("[TB] basic add");
      applyStimulus(1, 0, 0, nul);
      applyStimulus(0, 0, 1, tbl[0]);
      checkOutput("add wdata", imem_wdata, 32'h00221820);
      checkOutput("add addr", 32'(imem_addr), 32'h0);
      checkOutput("add count", 32'(word_count), 32'd1);

      $display("[TB] back-to-back addi/bgez");
      applyStimulus(1, 0, 0, nul);
      applyStimulus(0, 0, 1, tbl[11]);
      checkOutput("addi we", 32'(imem_we), 32'h1);
      checkOutput("addi wdata", imem_wdata, 32'h2008FFFF);
      applyStimulus(0, 0, 1, mkVec(OP_BGEZ, 4, 0, 0, 0, 3, 0, 32'h0));
      checkOutput("bgez we", 32'(imem_we), 32'h1);
      checkOutput("bgez addr", 32'(imem_addr), 32'h1);
      checkOutput("bgez wdata", imem_wdata, 32'h04810003);

      $display("[TB] encoding table");
      applyStimulus(1, 0, 0, nul);
      for (int i = 0; i < 12; i++) begin
         applyStimulus(0, 0, 1, tbl[i]);
         checkOutput($sformatf("tbl%0d wdata", i), imem_wdata, tbl[i].expWord);
         checkOutput($sformatf("tbl%0d addr", i), 32'(imem_addr), 32'(i));
      end

      $display("[TB] finish with jal");
      applyStimulus(1, 0, 0, nul);
      applyStimulus(0, 1, 1, mkVec(OP_JAL, 0, 0, 0, 0, 0, 26'h0000010, 32'h0));
      checkOutput("jal we", 32'(imem_we), 32'h1);
      checkOutput("jal wdata", imem_wdata, 32'h0C000010);
      checkOutput("done ready", 32'(in_ready), 32'h0);
      applyStimulus(0, 0, 1, tbl[0]);
      checkOutput("done no write", 32'(imem_we), 32'h0);

      $display("[TB] small memory fill");
      applyStimulus(1, 0, 0, nul);
      smallWrites = 0;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(0, 0, 1, tbl[9]);
         checkOutput($sformatf("small we%0d", i), 32'(sWe), 32'(i < 4));
         if (sWe) begin
            checkOutput($sformatf("small addr%0d", i), 32'(sAddr), 32'(smallWrites));
            smallWrites++;
         end
      end
      checkOutput("small writes", 32'(smallWrites), 32'd4);
      checkOutput("small full", 32'(sFull), 32'h1);
      checkOutput("small ready", 32'(sReady), 32'h0);
      checkOutput("small count", 32'(sCount), 32'd4);
      checkOutput("small addr hold", 32'(sAddr), 32'd3);

      $display("[TB] illegal op");
      applyStimulus(1, 0, 0, nul);
      applyStimulus(0, 0, 1, tbl[0]);
      applyStimulus(0, 0, 1, mkVec(31, 1, 2, 3, 4, 5, 6, 32'h0));
      checkOutput("illegal we", 32'(imem_we), TRAP ? 32'h0 : 32'h1);
      checkOutput("illegal count", 32'(word_count), TRAP ? 32'd1 : 32'd2);
      checkOutput("illegal err", 32'(err), 32'(TRAP));
      if (!TRAP) checkOutput("illegal wdata", imem_wdata, 32'h0);

      $display("[TB] reset mid-session");
      applyStimulus(1, 0, 0, nul);
      start = 1'b0; in_valid = 1'b1;
      in_op = OP_ADD; in_rs = 5'd1; in_rt = 5'd2; in_rd = 5'd3;
      @(posedge Clk);
      Reset = 1'b1;
      in_valid = 1'b0;
      #1;
      checkAllZero("async reset");
      @(negedge Clk);
      checkAllZero("held reset");
      @(negedge Clk);
      Reset = 1'b0;
      modelReset();
      applyStimulus(0, 0, 1, tbl[0]);
      applyStimulus(0, 0, 1, tbl[1]);
      checkOutput("post-reset we", 32'(imem_we), 32'h0);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 400; i++) begin
         v = mkVec($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                   $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 65535),
                   int'($urandom() & 32'h03FFFFFF), 32'h0);
         applyStimulus($urandom_range(0, 99) < 4, $urandom_range(0, 99) < 3,
                       $urandom_range(0, 99) < 80, v);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
